action_scheduler: RTL and testbench
===================================

# action_scheduler

Arbitrates the asynchronous event sources of the Tamagotchi (debounced Sleep/Feed/Play buttons, mic wake signal, ultrasonic turn detect, Test button) into one serialized command stream for the central FSM. Each source's rising edge is latched as a pending request. One request at a time is granted with fixed priority over a valid/ack handshake. A cooldown follows each grant, and requests invalid for the pet's current state are filtered out. Sits between the button/sensor front-ends and `FSM_Central`, replacing their direct wiring.

## Interface
Parameters:
- `COOLDOWN_CYCLES`, 25_000_000: idle cycles enforced after each completed or timed-out grant (0.5 s at 50 MHz).
- `ACK_TIMEOUT`, 50_000_000: maximum cycles `cmd_valid` stays high without `cmd_ack`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `req_sleep`, `req_awake`, `req_feed`, `req_play`, `req_giro`, `req_test` in 1 each: level inputs; the rising edge is the request.
- `asleep` in 1: FSM status; 1 while the pet is in the sleep state.
- `cmd_ack` in 1: FSM accepted the current command.
- `cmd_valid` out 1: command offered.
- `cmd_code` out 3: 0 none, 1 sleep, 2 awake, 3 feed, 4 play, 5 giro, 6 test.
- `pending` out 6: pending bits in the order {test, giro, play, feed, awake, sleep}.
- `timeout_err` out 1: one-cycle pulse when a grant is abandoned.
- `drop_cnt` out 8: saturating count of filtered requests.

## Operation
- Edge detection: each `req_*` is registered once per cycle. A rising edge is a current sample of 1 with a previous sample of 0. Each edge sets its pending bit on the next clock.
- An edge on a bit that is already pending is merged: no change, no count.
- Sleep filter: while `asleep`=1:
  - edges on sleep, feed, play and giro are discarded, and each discarded edge increments `drop_cnt` (saturates at 255);
  - those four pending bits are cleared;
  - awake and test are always accepted.
- Priority, highest first: test, awake, sleep, feed, play, giro.
- States:
  - IDLE: if `pending`≠0, latch the highest-priority code, clear that pending bit, go to GRANT.
  - GRANT: `cmd_valid`=1 and `cmd_code` is held stable. On `cmd_ack`=1, go to COOLDOWN. After ACK_TIMEOUT cycles without ack, pulse `timeout_err` and go to COOLDOWN; the command is dropped, not re-queued.
  - COOLDOWN: `cmd_valid`=0, `cmd_code`=0. Count COOLDOWN_CYCLES, then go to IDLE. New edges are still latched during this state.
- If a new edge on the granted source coincides with the cycle its bit is cleared at grant, set wins and the bit stays pending.
- `cmd_ack` outside GRANT is ignored.

## Timing
- Reset values: state IDLE, `cmd_valid`=0, `cmd_code`=0, `pending`=0, `timeout_err`=0, `drop_cnt`=0, edge registers=0. A level that is already high at reset release therefore counts as an edge.
- Latency: input rises in cycle t → pending bit set at t+1 → `cmd_valid` rises at t+2, provided the block is IDLE.
- Handshake: `cmd_ack` sampled high in cycle g → `cmd_valid` low at g+1 → IDLE re-entered at g+1+COOLDOWN_CYCLES.
- Timeout: the pulse appears on the cycle `cmd_valid` falls.
- Reset mid-operation: on the next edge every register returns to its reset value; in-flight and pending commands are lost.
- `asleep` is applied in the same cycle it is sampled. No assumption is made about its timing relative to a grant: a command already in GRANT is completed even if `asleep` rises.

## Structure
- Shared `tama_defs.vh`: command code constants CMD_NONE…CMD_TEST and scheduler state encodings. `FSM_Central` uses the same command codes.
- Sub-module `req_latch`, instantiated once per source: edge detector plus pending bit with set/clear/filter inputs, returns a drop strobe.
- Top level holds the priority encoder, the state machine, the cooldown and timeout counter (one shared 26-bit counter), and `drop_cnt`.
- Target size: about 150–250 lines of RTL.

## Test plan
All scenarios run with COOLDOWN_CYCLES=4 and ACK_TIMEOUT=8.
1. Single request: `req_feed` rises at cycle 10 → `cmd_valid`=1 with code 3 at cycle 12. Ack at 14 → `cmd_valid`=0 at 15; a new grant is possible from cycle 19.
2. Simultaneous requests: feed, play and test rise together → grants issued in order 6, 3, 4, each separated by a 4-cycle cooldown; `pending` ends at 0.
3. Sleep filter: with `asleep`=1, pulse feed, play, giro, then awake → only code 2 is granted; `drop_cnt`=3. Repeating for 300 filtered edges → `drop_cnt` holds at 255.
4. Timeout: grant code 4 with no ack → `cmd_valid` falls and `timeout_err` pulses 8 cycles after the grant; code 4 is not re-offered.
5. Merge and reset: two `req_play` edges while in COOLDOWN → exactly one code 4 is granted. Asserting `rst` during GRANT → `cmd_valid`=0 and `pending`=0 on the next cycle.

Source files
------------

// File: rtl/action_scheduler_pkg.sv
// Shared command codes, scheduler states and source ordering for the action scheduler.
// Command codes are common with the central pet FSM, so keep them in step with it.
package action_scheduler_pkg;

   localparam int NUM_SRC = 6;
   localparam int CNT_W   = 26;

   // Pending-vector bit positions: {test, giro, play, feed, awake, sleep}
   localparam int SRC_SLEEP = 0;
   localparam int SRC_AWAKE = 1;
   localparam int SRC_FEED  = 2;
   localparam int SRC_PLAY  = 3;
   localparam int SRC_GIRO  = 4;
   localparam int SRC_TEST  = 5;

   // Sources that make no sense while the pet sleeps
   localparam logic [NUM_SRC-1:0] SLEEP_FILTER_MASK = 6'b01_1101;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_SLEEP = 3'd1,
      CMD_AWAKE = 3'd2,
      CMD_FEED  = 3'd3,
      CMD_PLAY  = 3'd4,
      CMD_GIRO  = 3'd5,
      CMD_TEST  = 3'd6
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_COOLDOWN = 2'd2
   } sched_state_e;

   // Fixed priority: test, awake, sleep, feed, play, giro
   function automatic cmd_e pick_code(input logic [NUM_SRC-1:0] elig);
      if (elig[SRC_TEST])       pick_code = CMD_TEST;
      else if (elig[SRC_AWAKE]) pick_code = CMD_AWAKE;
      else if (elig[SRC_SLEEP]) pick_code = CMD_SLEEP;
      else if (elig[SRC_FEED])  pick_code = CMD_FEED;
      else if (elig[SRC_PLAY])  pick_code = CMD_PLAY;
      else if (elig[SRC_GIRO])  pick_code = CMD_GIRO;
      else                      pick_code = CMD_NONE;
   endfunction

endpackage

// File: rtl/action_scheduler_req_latch.sv
// Rising-edge detector plus pending bit; edge sets the bit one cycle later, filter clears it.
// No backpressure: edges on an already-pending bit merge, filtered edges raise a drop strobe.
module action_scheduler_req_latch (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic filter,
   input  logic clr,
   output logic pending,
   output logic drop
);

   logic req_q;
   logic pend_q;
   logic pend_d;
   logic edge_det;

   always_comb begin
      edge_det = req & ~req_q;
      drop     = filter & edge_det;
      pend_d   = pend_q;
      // A fresh edge beats the grant-time clear
      if (filter)
         pend_d = 1'b0;
      else if (edge_det)
         pend_d = 1'b1;
      else if (clr)
         pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         req_q  <= req;
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;

endmodule

// File: rtl/action_scheduler.sv
// Serialises button/sensor events into one command stream; edge to cmd_valid is 2 cycles from IDLE.
// Backpressure: cmd_valid holds until cmd_ack or ACK_TIMEOUT, then a COOLDOWN_CYCLES gap; edges keep latching.
module action_scheduler
   import action_scheduler_pkg::*;
#(
   parameter int COOLDOWN_CYCLES = 25_000_000,
   parameter int ACK_TIMEOUT     = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_sleep,
   input  logic       req_awake,
   input  logic       req_feed,
   input  logic       req_play,
   input  logic       req_giro,
   input  logic       req_test,
   input  logic       asleep,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic [5:0] pending,
   output logic       timeout_err,
   output logic [7:0] drop_cnt
);

   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

   sched_state_e       state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               cmd_valid_q;
   cmd_e               cmd_code_q;
   logic               timeout_q;
   logic [7:0]         drop_cnt_q;
   logic [7:0]         drop_cnt_d;

   logic [NUM_SRC-1:0] req_vec;
   logic [NUM_SRC-1:0] filter_vec;
   logic [NUM_SRC-1:0] pend_vec;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] drop_vec;
   logic [NUM_SRC-1:0] eligible;
   cmd_e               sel_code;
   logic [2:0]         drop_sum;
   logic [8:0]         drop_ext;

   assign req_vec    = {req_test, req_giro, req_play, req_feed, req_awake, req_sleep};
   assign filter_vec = asleep ? SLEEP_FILTER_MASK : '0;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      action_scheduler_req_latch u_latch (
         .clk     (clk),
         .rst     (rst),
         .req     (req_vec[g]),
         .filter  (filter_vec[g]),
         .clr     (clr_vec[g]),
         .pending (pend_vec[g]),
         .drop    (drop_vec[g])
      );
   end

   // Filtered bits are being cleared this cycle, so they must not win the grant either
   always_comb begin
      eligible = pend_vec & ~filter_vec;
      sel_code = pick_code(eligible);
      clr_vec  = '0;
      for (int i = 0; i < NUM_SRC; i++)
         clr_vec[i] = (state_q == ST_IDLE) && (sel_code == cmd_e'(3'(i + 1)));
   end

   always_comb begin
      drop_sum = '0;
      for (int i = 0; i < NUM_SRC; i++)
         drop_sum = drop_sum + 3'(drop_vec[i]);
      drop_ext   = {1'b0, drop_cnt_q} + {6'b0, drop_sum};
      drop_cnt_d = drop_ext[8] ? 8'hFF : drop_ext[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= CMD_NONE;
         timeout_q   <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         timeout_q  <= 1'b0;
         drop_cnt_q <= drop_cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (sel_code != CMD_NONE) begin
                  state_q     <= ST_GRANT;
                  cnt_q       <= '0;
                  cmd_valid_q <= 1'b1;
                  cmd_code_q  <= sel_code;
               end
            end
            ST_GRANT: begin
               if (cmd_ack || (cnt_q == ACK_LAST)) begin
                  // Unacknowledged commands are dropped, never re-queued
                  timeout_q   <= ~cmd_ack;
                  cmd_valid_q <= 1'b0;
                  cmd_code_q  <= CMD_NONE;
                  cnt_q       <= '0;
                  state_q     <= (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOLDOWN;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_COOLDOWN: begin
               if (cnt_q == COOL_LAST) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= '0;
               cmd_valid_q <= 1'b0;
               cmd_code_q  <= CMD_NONE;
            end
         endcase
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_code    = cmd_code_q;
   assign pending     = pend_vec;
   assign timeout_err = timeout_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Directed bench for action_scheduler with COOLDOWN_CYCLES=4 and ACK_TIMEOUT=8.
module tb_action_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_sleep, req_awake, req_feed, req_play, req_giro, req_test;
   logic       asleep;
   logic       cmd_ack;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic [5:0] pending;
   logic       timeout_err;
   logic [7:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   action_scheduler #(
      .COOLDOWN_CYCLES (4),
      .ACK_TIMEOUT     (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_sleep   (req_sleep),
      .req_awake   (req_awake),
      .req_feed    (req_feed),
      .req_play    (req_play),
      .req_giro    (req_giro),
      .req_test    (req_test),
      .asleep      (asleep),
      .cmd_ack     (cmd_ack),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .pending     (pending),
      .timeout_err (timeout_err),
      .drop_cnt    (drop_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ack the live grant, confirm valid drops, then ride out the 4-cycle cooldown
   // plus the IDLE decision cycle so any next grant is visible on return.
   task automatic ack_and_cool(input string tag);
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
      check(tag, {28'd0, cmd_valid, cmd_code}, 32'h0);
      repeat (5) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      {req_sleep, req_awake, req_feed, req_play, req_giro, req_test} = '0;
      asleep  = 1'b0;
      cmd_ack = 1'b0;
      step();
      step();
      check("rst_valid",   {31'd0, cmd_valid},   32'd0);
      check("rst_code",    {29'd0, cmd_code},    32'd0);
      check("rst_pending", {26'd0, pending},     32'd0);
      check("rst_timeout", {31'd0, timeout_err}, 32'd0);
      check("rst_drop",    {24'd0, drop_cnt},    32'd0);
      rst = 1'b0;

      // Single feed request, ack, cooldown spacing to a following play grant
      req_feed = 1'b1;
      step();
      check("s1_pend", {26'd0, pending}, 32'b000100);
      check("s1_novalid", {31'd0, cmd_valid}, 32'd0);
      step();
      check("s1_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd3});
      check("s1_pclr", {26'd0, pending}, 32'd0);
      req_feed = 1'b0;
      step();
      check("s1_hold", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd3});
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
      check("s1_ackfall", {28'd0, cmd_valid, cmd_code}, 32'd0);
      req_play = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("s1_cool", {31'd0, cmd_valid}, 32'd0);
      end
      req_play = 1'b0;
      check("s1_cool_pend", {26'd0, pending}, 32'b001000);
      step();
      check("s1_regrant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd4});
      ack_and_cool("s1_ack2");
      check("s1_idle", {31'd0, cmd_valid}, 32'd0);

      // Simultaneous feed/play/test: order test, feed, play
      req_feed = 1'b1; req_play = 1'b1; req_test = 1'b1;
      step();
      check("s2_pend", {26'd0, pending}, 32'b101100);
      step();
      check("s2_first", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd6});
      req_feed = 1'b0; req_play = 1'b0; req_test = 1'b0;
      ack_and_cool("s2_ack1");
      check("s2_second", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd3});
      ack_and_cool("s2_ack2");
      check("s2_third", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd4});
      ack_and_cool("s2_ack3");
      check("s2_empty", {26'd0, pending}, 32'd0);
      check("s2_idle", {31'd0, cmd_valid}, 32'd0);

      // Awake outranks sleep
      req_sleep = 1'b1; req_awake = 1'b1;
      step();
      step();
      check("s2_awake_first", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd2});
      req_sleep = 1'b0; req_awake = 1'b0;
      ack_and_cool("s2_ack4");
      check("s2_sleep_next", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd1});
      ack_and_cool("s2_ack5");

      // Grant in flight survives asleep; pending feed is wiped
      req_giro = 1'b1;
      step();
      step();
      check("s3_giro_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd5});
      req_giro = 1'b0; req_feed = 1'b1;
      step();
      req_feed = 1'b0;
      check("s3_feed_pend", {26'd0, pending}, 32'b000100);
      asleep = 1'b1;
      step();
      check("s3_feed_wiped", {26'd0, pending}, 32'd0);
      check("s3_grant_kept", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd5});
      ack_and_cool("s3_ack1");

      // Sleep filter: three dropped edges, awake still granted
      req_feed = 1'b1;
      step();
      req_feed = 1'b0; req_play = 1'b1;
      step();
      req_play = 1'b0; req_giro = 1'b1;
      step();
      req_giro = 1'b0; req_awake = 1'b1;
      step();
      req_awake = 1'b0;
      check("s3_drop3", {24'd0, drop_cnt}, 32'd3);
      check("s3_awake_pend", {26'd0, pending}, 32'b000010);
      step();
      check("s3_awake_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd2});
      ack_and_cool("s3_ack2");
      check("s3_nothing_more", {26'd0, pending}, 32'd0);
      check("s3_idle", {31'd0, cmd_valid}, 32'd0);

      // Saturation of drop_cnt
      for (int i = 0; i < 100; i++) begin
         req_giro = 1'b1;
         step();
         req_giro = 1'b0;
         step();
      end
      check("s3_drop103", {24'd0, drop_cnt}, 32'd103);
      for (int i = 0; i < 200; i++) begin
         req_giro = 1'b1;
         step();
         req_giro = 1'b0;
         step();
      end
      check("s3_drop_sat", {24'd0, drop_cnt}, 32'd255);
      check("s3_sat_pend", {26'd0, pending}, 32'd0);
      asleep = 1'b0;
      step();

      // Timeout on an unacked play grant
      req_play = 1'b1;
      step();
      step();
      check("s4_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd4});
      check("s4_no_to", {31'd0, timeout_err}, 32'd0);
      req_play = 1'b0;
      repeat (7) step();
      check("s4_hold7", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd4});
      check("s4_no_to7", {31'd0, timeout_err}, 32'd0);
      step();
      check("s4_fall", {31'd0, cmd_valid}, 32'd0);
      check("s4_pulse", {31'd0, timeout_err}, 32'd1);
      step();
      check("s4_pulse_end", {31'd0, timeout_err}, 32'd0);
      repeat (4) step();
      check("s4_not_reoffered", {31'd0, cmd_valid}, 32'd0);
      check("s4_pend_empty", {26'd0, pending}, 32'd0);

      // Two play edges during cooldown merge into one grant
      req_feed = 1'b1;
      step();
      step();
      check("s5_feed_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd3});
      req_feed = 1'b0;
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
      req_play = 1'b1;
      step();
      req_play = 1'b0;
      step();
      req_play = 1'b1;
      step();
      req_play = 1'b0;
      check("s5_merged", {26'd0, pending}, 32'b001000);
      check("s5_cool", {31'd0, cmd_valid}, 32'd0);
      step();
      step();
      check("s5_play_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd4});
      ack_and_cool("s5_ack");
      check("s5_single", {31'd0, cmd_valid}, 32'd0);
      check("s5_empty", {26'd0, pending}, 32'd0);

      // Reset during GRANT with another request pending
      req_sleep = 1'b1;
      step();
      req_test = 1'b1;
      step();
      check("s5_sleep_grant", {28'd0, cmd_valid, cmd_code}, {28'd0, 1'b1, 3'd1});
      check("s5_test_pend", {26'd0, pending}, 32'b100000);
      rst = 1'b1;
      req_sleep = 1'b0; req_test = 1'b0;
      step();
      check("s5_rst_valid", {28'd0, cmd_valid, cmd_code}, 32'd0);
      check("s5_rst_pend", {26'd0, pending}, 32'd0);
      check("s5_rst_drop", {24'd0, drop_cnt}, 32'd0);
      rst = 1'b0;
      step();
      step();
      check("s5_post_rst", {31'd0, cmd_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
